// File: rtl/rv_ctl_hs.sv
// rv_ctl_hs: multicycle RISC-V control FSM with a req/ready memory handshake,
// wait-state timeout, I-type ALU, BEQ/BNE/BLT/BGE, JAL, JALR and LUI.
// Optional feature macro: RV_CTL_ILLEGAL_TRAP_EN. When defined, unsupported
// instructions trap into the ILLEGAL state and raise the sticky 'illegal'
// output. When undefined, they retire as NOPs and the port does not exist.
module rv_ctl_hs #(
    parameter int TW          = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memrw,
    output logic [1:0]  pcsource,
    output logic        pcwrite,
    output logic        pccen,
    output logic        irwrite,
    output logic        mdrwrite,
    output logic [1:0]  wbsel,
    output logic        regwen,
    output logic [2:0]  immsel,
    output logic [1:0]  asel,
    output logic [1:0]  bsel,
    output logic [3:0]  alusel,
    output logic        mem_err,
    output logic [3:0]  state_o
`ifdef RV_CTL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_LW_MEM    = 4'd3,
        S_LW_WB     = 4'd4,
        S_SW_MEM    = 4'd5,
        S_RTYPE_ALU = 4'd6,
        S_ITYPE_ALU = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BR_EXEC   = 4'd9,
        S_JAL_EXEC  = 4'd10,
        S_JALR_EXEC = 4'd11,
        S_LUI_WB    = 4'd12,
        S_HALT      = 4'd13,
        S_ILLEGAL   = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] PC_INC      = 2'd0;
    localparam logic [1:0] PC_ALU      = 2'd1;
    localparam logic [1:0] PC_ALU_LSB0 = 2'd2;

    localparam logic [1:0] WB_PC     = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_MDR    = 2'd2;
    localparam logic [1:0] WB_IMM    = 2'd3;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] A_REG = 2'd0;
    localparam logic [1:0] A_PCC = 2'd1;
    localparam logic [1:0] B_REG = 2'd0;
    localparam logic [1:0] B_IMM = 2'd1;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam logic [TW-1:0] TMO     = TW'(MEM_TIMEOUT);
    localparam logic [TW-1:0] CNT_MAX = '1;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            ill_q, ill_d;
    logic            req_s;
    logic            timeout;
    logic            taken;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    state_t          bad_dest;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign timeout = (cnt_q == TMO);

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

`ifdef RV_CTL_ILLEGAL_TRAP_EN
    assign bad_dest = S_ILLEGAL;
    assign illegal  = ill_q;
`else
    assign bad_dest = S_FETCH;
`endif

    // Branch resolution from the datapath comparator flags.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            default: taken = 1'b0;
        endcase
    end

    // Next-state, control outputs and wait-counter update.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        req_s    = 1'b0;
        memrw    = 1'b0;
        pcsource = PC_INC;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        mdrwrite = 1'b0;
        wbsel    = WB_PC;
        regwen   = 1'b0;
        immsel   = IMM_B;
        asel     = A_REG;
        bsel     = B_REG;
        alusel   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                req_s = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    pccen   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                asel   = A_PCC;
                bsel   = B_IMM;
                immsel = IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? S_MEM_ADDR : bad_dest;
                    OP_RTYPE:          state_d = S_RTYPE_ALU;
                    OP_ITYPE:          state_d = S_ITYPE_ALU;
                    OP_BRANCH:         state_d = S_BR_EXEC;
                    OP_JAL:            state_d = S_JAL_EXEC;
                    OP_JALR:           state_d = (funct3 == 3'b000) ? S_JALR_EXEC : bad_dest;
                    OP_LUI:            state_d = S_LUI_WB;
                    default:           state_d = bad_dest;
                endcase
            end
            S_MEM_ADDR: begin
                bsel    = B_IMM;
                immsel  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d = (opcode == OP_STORE) ? S_SW_MEM : S_LW_MEM;
            end
            S_LW_MEM: begin
                req_s = 1'b1;
                if (mem_ready) begin
                    mdrwrite = 1'b1;
                    state_d  = S_LW_WB;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_LW_WB: begin
                wbsel   = WB_MDR;
                regwen  = 1'b1;
                state_d = S_FETCH;
            end
            S_SW_MEM: begin
                req_s = 1'b1;
                memrw = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_RTYPE_ALU: begin
                alusel  = {funct3, instr[30]};
                state_d = S_ALU_WB;
            end
            S_ITYPE_ALU: begin
                bsel    = B_IMM;
                immsel  = IMM_I;
                alusel  = (funct3 == 3'b101) ? {funct3, instr[30]} : {funct3, 1'b0};
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                wbsel   = WB_ALUOUT;
                regwen  = 1'b1;
                state_d = S_FETCH;
            end
            S_BR_EXEC: begin
                alusel   = ALU_SUB;
                pcsource = PC_ALU;
                pcwrite  = taken;
                state_d  = S_FETCH;
            end
            S_JAL_EXEC: begin
                asel     = A_PCC;
                bsel     = B_IMM;
                immsel   = IMM_J;
                pcsource = PC_ALU;
                pcwrite  = 1'b1;
                regwen   = 1'b1;
                wbsel    = WB_PC;
                state_d  = S_FETCH;
            end
            S_JALR_EXEC: begin
                // rd receives the already-incremented PC; the new PC lands on the same edge.
                bsel     = B_IMM;
                immsel   = IMM_I;
                pcsource = PC_ALU_LSB0;
                pcwrite  = 1'b1;
                regwen   = 1'b1;
                wbsel    = WB_PC;
                state_d  = S_FETCH;
            end
            S_LUI_WB: begin
                immsel  = IMM_U;
                wbsel   = WB_IMM;
                regwen  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT, S_ILLEGAL: state_d = state_q;
            default:           state_d = S_FETCH;
        endcase

        ill_d = ill_q | (state_d == S_ILLEGAL);

        if ((state_d != state_q) &&
            ((state_d == S_FETCH) || (state_d == S_LW_MEM) || (state_d == S_SW_MEM)))
            cnt_d = '0;
        else if (req_s && !mem_ready && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    // State, wait counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ill_q   <= ill_d;
        end
    end

    // A reset arriving mid-wait withdraws the request immediately.
    assign mem_req = req_s & ~rst;
    assign mem_err = err_q;
    assign state_o = state_q;

`ifndef RV_CTL_ILLEGAL_TRAP_EN
    logic unused_ill;
    assign unused_ill = ill_q;
`endif

endmodule

// File: tb/tb_rv_ctl_hs.sv
// tb_rv_ctl_hs: scoreboard bench for rv_ctl_hs. Per-cycle expected control
// vectors are queued as stimulus is applied and compared on the falling edge.
module tb_rv_ctl_hs;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       rw;
        logic [1:0] pcs;
        logic       pcw;
        logic       pcc;
        logic       irw;
        logic       mdrw;
        logic [1:0] wb;
        logic       rwen;
        logic [2:0] imm;
        logic [1:0] as;
        logic [1:0] bs;
        logic [3:0] alu;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero, lt, mem_ready;
    logic        mem_req, memrw, pcwrite, pccen, irwrite, mdrwrite, regwen, mem_err;
    logic [1:0]  pcsource, wbsel, asel, bsel;
    logic [2:0]  immsel;
    logic [3:0]  alusel, state_o;
`ifdef RV_CTL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    rv_ctl_hs #(.TW(8), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .mem_req(mem_req), .memrw(memrw),
        .pcsource(pcsource), .pcwrite(pcwrite), .pccen(pccen),
        .irwrite(irwrite), .mdrwrite(mdrwrite), .wbsel(wbsel),
        .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
        .alusel(alusel), .mem_err(mem_err), .state_o(state_o)
`ifdef RV_CTL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard consumer: compare the full control vector mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e, o;
            e = sb.pop_front();
            o = {state_o, mem_req, memrw, pcsource, pcwrite, pccen, irwrite, mdrwrite,
                 wbsel, regwen, immsel, asel, bsel, alusel, mem_err};
            check_val($sformatf("st%0d", e.st), 32'(o), 32'(e));
        end
    end

    function automatic exp_t dflt(input logic [3:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.imm = 3'd2;
        return e;
    endfunction

    task automatic cyc(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] ins, input int waits);
        exp_t e;
        instr = ins;
        mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            e = dflt(4'd0); e.req = 1'b1;
            cyc(e);
        end
        mem_ready = 1'b1;
        e = dflt(4'd0); e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.pcc = 1'b1;
        cyc(e);
        mem_ready = 1'b0;
        e = dflt(4'd1); e.as = 2'd1; e.bs = 2'd1;
        cyc(e);
    endtask

    task automatic alu_wb();
        exp_t e;
        e = dflt(4'd8); e.wb = 2'd1; e.rwen = 1'b1;
        cyc(e);
    endtask

    task automatic itype(input logic [31:0] ins, input logic [3:0] alu);
        exp_t e;
        do_fetch(ins, 0);
        e = dflt(4'd7); e.bs = 2'd1; e.imm = 3'd0; e.alu = alu;
        cyc(e);
        alu_wb();
    endtask

    task automatic branch(input logic [31:0] ins, input logic z, input logic l,
                          input logic tk, input int waits);
        exp_t e;
        do_fetch(ins, waits);
        zero = z; lt = l;
        e = dflt(4'd9); e.alu = 4'b0001; e.pcs = 2'd1; e.pcw = tk;
        cyc(e);
        zero = 1'b0; lt = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_val("rst_state", 32'(state_o), 32'd0);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b1; instr = 32'h0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
        #1;
        check_val("rst_state", 32'(state_o), 32'd0);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADDI x1,x0,5 ; ADDI with bit30 set stays ADD ; SRAI picks up bit30
        itype(32'h00500093, 4'b0000);
        itype(32'h40008093, 4'b0000);
        itype(32'h4030D093, 4'b1011);

        // SUB x3,x1,x2
        do_fetch(32'h402081B3, 0);
        e = dflt(4'd6); e.alu = 4'b0001;
        cyc(e);
        alu_wb();

        // LW x1,0(x2) with 3 wait cycles on both accesses
        do_fetch(32'h00012083, 3);
        e = dflt(4'd2); e.bs = 2'd1; e.imm = 3'd0;
        cyc(e);
        for (int i = 0; i < 3; i++) begin
            e = dflt(4'd3); e.req = 1'b1;
            cyc(e);
        end
        mem_ready = 1'b1;
        e = dflt(4'd3); e.req = 1'b1; e.mdrw = 1'b1;
        cyc(e);
        mem_ready = 1'b0;
        e = dflt(4'd4); e.wb = 2'd2; e.rwen = 1'b1;
        cyc(e);

        // SW x1,0(x2): ready arrives exactly on the timeout-compare cycle
        do_fetch(32'h00112023, 0);
        e = dflt(4'd2); e.bs = 2'd1; e.imm = 3'd1;
        cyc(e);
        for (int i = 0; i < 4; i++) begin
            e = dflt(4'd5); e.req = 1'b1; e.rw = 1'b1;
            cyc(e);
        end
        mem_ready = 1'b1;
        e = dflt(4'd5); e.req = 1'b1; e.rw = 1'b1;
        cyc(e);
        mem_ready = 1'b0;

        // Branches: BNE zero=0 taken (fetch at timeout boundary), BLT lt=0 not taken,
        // BEQ zero=1 taken, BGE lt=1 not taken
        branch(32'h00209463, 1'b0, 1'b0, 1'b1, 4);
        branch(32'h0020C463, 1'b0, 1'b0, 1'b0, 0);
        branch(32'h00208463, 1'b1, 1'b0, 1'b1, 0);
        branch(32'h0020D463, 1'b0, 1'b1, 1'b0, 0);

        // JAL x1,8
        do_fetch(32'h008000EF, 0);
        e = dflt(4'd10); e.as = 2'd1; e.bs = 2'd1; e.imm = 3'd3; e.pcs = 2'd1;
        e.pcw = 1'b1; e.rwen = 1'b1;
        cyc(e);

        // JALR x1,0(x2)
        do_fetch(32'h000100E7, 0);
        e = dflt(4'd11); e.bs = 2'd1; e.imm = 3'd0; e.pcs = 2'd2;
        e.pcw = 1'b1; e.rwen = 1'b1;
        cyc(e);

        // LUI x1,0x12345
        do_fetch(32'h123450B7, 0);
        e = dflt(4'd12); e.imm = 3'd4; e.wb = 2'd3; e.rwen = 1'b1;
        cyc(e);

        // Fetch timeout: 4 wait cycles then the compare cycle, then HALT
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e = dflt(4'd0); e.req = 1'b1;
            cyc(e);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = dflt(4'd13); e.err = 1'b1;
            cyc(e);
        end
        mem_ready = 1'b0;
        do_reset();

        // Unsupported opcode 0x7F and LB (funct3 000)
`ifdef RV_CTL_ILLEGAL_TRAP_EN
        do_fetch(32'h0000007F, 0);
        check_val("illegal_set", 32'(illegal), 32'd1);
        for (int i = 0; i < 2; i++) cyc(dflt(4'd14));
        do_reset();
        check_val("illegal_clr", 32'(illegal), 32'd0);
        do_fetch(32'h00010083, 0);
        check_val("illegal_lb", 32'(illegal), 32'd1);
        cyc(dflt(4'd14));
        do_reset();
`else
        do_fetch(32'h0000007F, 0);
        e = dflt(4'd0); e.req = 1'b1;
        cyc(e);
        do_fetch(32'h00010083, 0);
        e = dflt(4'd0); e.req = 1'b1;
        cyc(e);
`endif
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_ctl_hs.md
Name: rv_ctl_hs

Overview:
Multicycle RISC-V control FSM, second generation. Extends the single-cycle-memory controller in three ways:
- Adds a req/ready memory handshake with wait states and a timeout.
- Adds I-type ALU, full BEQ/BNE/BLT/BGE branching, JALR and LUI.
- Exposes its state for debug.
Sits between the instruction register/datapath and the unified memory port of the multicycle core.

Parameters:
TW, 8, width of memory wait counter
MEM_TIMEOUT, 200, wait cycles without mem_ready before the error halt; legal range 1..2^TW-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr  in  32  instruction register contents
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2 from datapath comparator
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request valid
memrw  out  1  1 = write, 0 = read; valid with mem_req
pcsource  out  2  0 PC_INC, 1 PC_ALU, 2 PC_ALU_LSB0 (JALR, bit0 cleared in datapath)
pcwrite  out  1  PC load enable
pccen  out  1  PC-current (old PC) capture enable
irwrite  out  1  instruction register load
mdrwrite  out  1  memory data register load
wbsel  out  2  0 WB_PC, 1 WB_ALUOUT, 2 WB_MDR, 3 WB_IMM
regwen  out  1  register file write enable
immsel  out  3  0 I, 1 S, 2 B, 3 J, 4 U
asel  out  2  0 REG, 1 PCC, 2 ALUOUT
bsel  out  2  0 REG, 1 IMM, 2 ONE
alusel  out  4  ALU op; ADD=0000, SUB=0001; otherwise {funct3, bit}
mem_err  out  1  sticky timeout flag
state_o  out  4  current state encoding, debug

Behaviour:
- Reset: state FETCH, wait counter 0, mem_err 0.
- Output defaults in every state: all enables 0, pcsource 0, wbsel 0, immsel 2, asel 0, bsel 0, alusel ADD.
- Decode key: {opcode, funct3}.
- Supported opcodes: LW 0000011/010, SW 0100011/010, R-type 0110011, I-type ALU 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111/000, LUI 0110111.
- States (state_o value):
  - FETCH(0): mem_req=1, memrw=0. Stays until mem_ready. In the mem_ready cycle: irwrite, pcwrite, pccen=1, pcsource PC_INC, then -> DECODE.
  - DECODE(1): asel PCC, bsel IMM, immsel B, ADD (branch target precompute). Next state: LW/SW -> MEM_ADDR; R -> RTYPE_ALU; I -> ITYPE_ALU; BRANCH -> BR_EXEC; JAL -> JAL_EXEC; JALR -> JALR_EXEC; LUI -> LUI_WB; other -> FETCH (see optional feature).
  - MEM_ADDR(2): asel REG, bsel IMM, immsel I for LW / S for SW, ADD. Next: LW_MEM or SW_MEM.
  - LW_MEM(3): mem_req=1, memrw=0. On mem_ready: mdrwrite=1 -> LW_WB.
  - LW_WB(4): wbsel MDR, regwen -> FETCH.
  - SW_MEM(5): mem_req=1, memrw=1. On mem_ready -> FETCH.
  - RTYPE_ALU(6): asel REG, bsel REG, alusel {funct3, instr[30]} -> ALU_WB.
  - ITYPE_ALU(7): asel REG, bsel IMM, immsel I. alusel {funct3, instr[30]} when funct3=101, else {funct3, 0} (ADDI never SUB) -> ALU_WB.
  - ALU_WB(8): wbsel ALUOUT, regwen -> FETCH.
  - BR_EXEC(9): asel REG, bsel REG, SUB, pcsource PC_ALU. pcwrite = taken, where taken is: funct3 000 zero; 001 !zero; 100 lt; 101 !lt; other funct3 0. -> FETCH.
  - JAL_EXEC(10): asel PCC, bsel IMM, immsel J, ADD, pcsource PC_ALU, pcwrite, regwen, wbsel PC -> FETCH.
  - JALR_EXEC(11): asel REG, bsel IMM, immsel I, ADD, pcsource PC_ALU_LSB0, pcwrite, regwen, wbsel PC -> FETCH. The rd write uses the pre-edge incremented PC.
  - LUI_WB(12): immsel U, wbsel IMM, regwen -> FETCH.
  - HALT(13): all outputs at defaults. Left only by rst.
  - ILLEGAL(14): see optional feature.
- Wait counter:
  - Cleared on entry to FETCH, LW_MEM and SW_MEM.
  - Increments each cycle mem_req=1 && mem_ready=0, saturating at 2^TW-1.
  - When counter == MEM_TIMEOUT and mem_ready=0: mem_err<=1, next -> HALT, no enable asserted that cycle.
  - mem_ready in the same cycle as the timeout compare wins: normal completion.
- mem_req is purely state-derived; it must not depend combinationally on mem_ready.
- Reset mid-wait drops mem_req in the same cycle (async); the memory must tolerate an abandoned request.

Optional Feature:
RV_CTL_ILLEGAL_TRAP_EN
- Defined: output illegal (1 bit, sticky, reset 0) added. Unsupported decode in DECODE, or LW/SW with a funct3 other than 010, -> ILLEGAL(14). ILLEGAL sets illegal=1 and holds with all outputs at defaults until rst.
- Undefined: these instructions -> FETCH as a NOP; no illegal port; state 14 unreachable.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready high each request -> states 0,1,7,8; regwen in state 8 with wbsel 1; alusel 0000.
- LW with mem_ready delayed 3 cycles in FETCH and LW_MEM -> mem_req held 4 cycles in each; irwrite and mdrwrite pulse once, only in the ready cycle.
- BNE with zero=0, then BLT with lt=0 -> pcwrite=1 in BR_EXEC for BNE; pcwrite=0 for BLT; both return to FETCH.
- JALR x1,0(x2) -> JALR_EXEC: pcsource 2, pcwrite, regwen, wbsel 0 all in one cycle.
- mem_ready held 0 with MEM_TIMEOUT=4 -> mem_err=1 after 4 wait cycles; state_o=13; stays halted until rst; rst clears mem_err.
- Opcode 0x0000007F: with RV_CTL_ILLEGAL_TRAP_EN, state_o=14 and illegal=1. Without it, back to FETCH with no regwen/pcwrite beyond the fetch.
